// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipelined select mux.
package pipe_pkg;

  localparam int MAX_NUM_IN = 16;

  // Select width for n inputs, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sel_mux_n.sv
// Combinational N-way index select; out-of-range indices yield zero and raise o_oor.
module sel_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_oor
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (i_sel == SEL_W'(k)) o_data = i_data[k*WIDTH +: WIDTH];
  end

  // Extra bit keeps the compare meaningful when NUM_IN == 2**SEL_W.
  assign o_oor = ({1'b0, i_sel} >= (SEL_W+1)'(NUM_IN));

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N:1 select with valid/ready handshake, head + skid storage, and flush.
module pipe_sel_mux
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } entry_t;

  if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
    $error("pipe_sel_mux: NUM_IN out of range");
  end

  entry_t           r_head, r_skid;
  logic             r_head_vld, r_skid_vld, r_sel_err;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_oor, w_acc, w_pop;
  entry_t           w_new;

  sel_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_data),
    .o_oor  (w_oor)
  );

  assign w_new = '{data: w_sel_data, sel: in_sel};
  assign w_acc = in_valid & ~r_skid_vld;
  assign w_pop = r_head_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_sel_err <= w_acc & w_oor & ~flush;
      if (flush) begin
        r_head_vld <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (w_pop) begin
        // Skid drains first; w_acc is necessarily low whenever the skid is full.
        if (r_skid_vld) begin
          r_head     <= r_skid;
          r_skid_vld <= 1'b0;
        end else if (w_acc) begin
          r_head <= w_new;
        end else begin
          r_head_vld <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_head_vld) begin
          r_head     <= w_new;
          r_head_vld <= 1'b1;
        end else begin
          r_skid     <= w_new;
          r_skid_vld <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = ~r_skid_vld;
  assign out_data  = r_head.data;
  assign out_sel   = r_head.sel;
  assign out_valid = r_head_vld;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench: a 4-input instance for datapath behaviour, a 3-input one for range errors.
module tb_pipe_sel_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int           checks = 0;
  int           errors = 0;

  // 4-input instance
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, sel_err;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;

  // 3-input instance
  logic [95:0]  in_data3 = '0;
  logic [1:0]   in_sel3 = '0;
  logic         in_valid3 = 1'b0, flush3 = 1'b0, out_ready3 = 1'b0;
  logic         in_ready3, out_valid3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  logic [31:0]  exp_seq [4] = '{32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD};

  always #5 clk = ~clk;

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    in_data = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'hCCCC) begin errors++; $display("FAIL single_data got=%h exp=cccc", out_data); end
    checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", out_sel); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); in_valid = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[s])
        begin errors++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", s, out_valid, out_data, exp_seq[s]); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", s, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_sel = 2'd0; in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_data !== 32'hAAAA)
      begin errors++; $display("FAIL bp_first got=%b/%h exp=1/aaaa", in_ready, out_data); end
    in_sel = 2'd1;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA || out_sel !== 2'd0)
      begin errors++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/aaaa/0", out_valid, out_data, out_sel); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hBBBB || out_sel !== 2'd1)
      begin errors++; $display("FAIL bp_second got=%b/%h/%0d exp=1/bbbb/1", out_valid, out_data, out_sel); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sel_err();
    in_data3 = {32'h3333, 32'h2222, 32'h1111};
    out_ready3 = 1'b1;
    in_sel3 = 2'd2; in_valid3 = 1'b1;
    tick();
    checks++; if (out_data3 !== 32'h3333 || sel_err3 !== 1'b0)
      begin errors++; $display("FAIL oor_inrange got=%h/%b exp=3333/0", out_data3, sel_err3); end
    in_sel3 = 2'd3;
    tick();
    in_valid3 = 1'b0;
    checks++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0 || out_sel3 !== 2'd3)
      begin errors++; $display("FAIL oor_entry got=%b/%h/%0d exp=1/0/3", out_valid3, out_data3, out_sel3); end
    checks++; if (sel_err3 !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", sel_err3); end
    tick();
    checks++; if (sel_err3 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got=%b exp=0", sel_err3); end
    // Out-of-range accept coinciding with flush must not flag an error.
    in_sel3 = 2'd3; in_valid3 = 1'b1; flush3 = 1'b1;
    tick();
    in_valid3 = 1'b0; flush3 = 1'b0;
    checks++; if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0)
      begin errors++; $display("FAIL oor_flush got=%b/%b exp=0/0", sel_err3, out_valid3); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_sel = 2'd0; in_valid = 1'b1;
    tick();
    in_sel = 2'd1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full got=%b exp=0", in_ready); end
    in_sel = 2'd2; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_clear got=%b/%b exp=0/1", out_valid, in_ready); end
    // Head empty: the same-cycle accept is dropped by flush.
    in_sel = 2'd2; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_left got=%b exp=0", out_valid); end
    in_sel = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDDDD)
      begin errors++; $display("FAIL flush_next got=%b/%h exp=1/dddd", out_valid, out_data); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_sel = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL areset_immediate got=%b/%b exp=0/1", out_valid, in_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1; in_sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hCCCC)
      begin errors++; $display("FAIL areset_after got=%b/%h exp=1/cccc", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_sel_err();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
